// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini-SRC single-bus datapath: fetch in T0-T2,
// execute in T3-T7, with memory wait states held until mem_ready is sampled high.
module control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        OutPortin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

  typedef struct packed {
    logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out;
    logic pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, outport_in;
    logic gra, grb, grc, r_in, r_out, ba_out, inc_pc, read, write, illegal;
    logic [4:0] alu_op;
  } ctl_t;

  localparam logic [4:0] OP_LD = 5'd0, OP_ST = 5'd2, OP_HALT = 5'd27;

  state_t     state, state_next;
  ctl_t       c, ctl;
  logic [4:0] op;
  logic [3:0] step_full;
  logic [2:0] step, last_step;
  logic       in_wait;
  logic       ir_unused;

  assign op        = ir[31:27];
  assign ir_unused = ^ir[26:0];
  assign step_full = state - T3;
  assign step      = step_full[2:0];

  // Index of the final execute step, and whether this step is a memory wait.
  always_comb begin
    last_step = 3'd0;
    if (op == OP_LD || op == OP_ST)                   last_step = 3'd4;
    else if (op == 5'd1 || (op >= 5'd3 && op <= 5'd14)) last_step = 3'd2;
    else if (op == 5'd15 || op == 5'd16)              last_step = 3'd3;
    else if (op == 5'd17 || op == 5'd18)              last_step = 3'd1;
    in_wait = (op == OP_LD && step == 3'd3) || (op == OP_ST && step == 3'd4);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= T0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      T0: state_next = T1;
      T1: if (mem_ready) state_next = T2;
      T2: state_next = T3;
      T3, T4, T5, T6, T7: begin
        if (state == T3 && op == OP_HALT) state_next = HALT;
        else if (in_wait && !mem_ready)   state_next = state;
        else if (step == last_step)       state_next = T0;
        else                              state_next = state_t'(state + 4'd1);
      end
      HALT: state_next = HALT;
      default: state_next = T0;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
      T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
      T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      T3, T4, T5, T6, T7: begin
        if (op >= 5'd3 && op <= 5'd14) begin
          case (step)
            3'd0: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            3'd1: begin
              c.z_in = 1'b1;
              if (op <= 5'd11) begin
                c.grc = 1'b1; c.r_out = 1'b1; c.alu_op = op;
              end else begin
                c.c_out  = 1'b1;
                c.alu_op = (op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6;
              end
            end
            default: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          endcase
        end else if (op <= 5'd2) begin
          // ldi, ld and st share the base-plus-constant address computation.
          case (step)
            3'd0: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            3'd1: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = 5'd3; end
            3'd2: begin
              c.zlow_out = 1'b1;
              if (op == 5'd1) begin c.gra = 1'b1; c.r_in = 1'b1; end
              else            c.mar_in = 1'b1;
            end
            3'd3: begin
              c.mdr_in = 1'b1;
              if (op == OP_LD) c.read = 1'b1;
              else begin c.gra = 1'b1; c.r_out = 1'b1; end
            end
            default: begin
              if (op == OP_LD) begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
              else             c.write = 1'b1;
            end
          endcase
        end else if (op == 5'd15 || op == 5'd16) begin
          case (step)
            3'd0: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            3'd1: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; end
            3'd2: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
            default: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          endcase
        end else if (op == 5'd17 || op == 5'd18) begin
          if (step == 3'd0) begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op; end
          else begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
        end else begin
          case (op)
            5'd20: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            5'd22: begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            5'd23: begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
            5'd24: begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            5'd25: begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            5'd26, OP_HALT: ;
            default: c.illegal = (state == T3);
          endcase
        end
      end
      default: ;
    endcase
  end

  // Reset silences every strobe immediately so a pending memory access drops.
  assign ctl       = reset ? '0 : c;
  assign run       = !reset && (state != HALT);
  assign dbg_state = state;

  assign PCout     = ctl.pc_out;
  assign Zhighout  = ctl.zhigh_out;
  assign Zlowout   = ctl.zlow_out;
  assign MDRout    = ctl.mdr_out;
  assign HIout     = ctl.hi_out;
  assign LOout     = ctl.lo_out;
  assign InPortout = ctl.inport_out;
  assign Cout      = ctl.c_out;
  assign PCin      = ctl.pc_in;
  assign IRin      = ctl.ir_in;
  assign MARin     = ctl.mar_in;
  assign MDRin     = ctl.mdr_in;
  assign Yin       = ctl.y_in;
  assign Zin       = ctl.z_in;
  assign HIin      = ctl.hi_in;
  assign LOin      = ctl.lo_in;
  assign OutPortin = ctl.outport_in;
  assign Gra       = ctl.gra;
  assign Grb       = ctl.grb;
  assign Grc       = ctl.grc;
  assign Rin       = ctl.r_in;
  assign Rout      = ctl.r_out;
  assign BAout     = ctl.ba_out;
  assign IncPC     = ctl.inc_pc;
  assign Read      = ctl.read;
  assign Write     = ctl.write;
  assign illegal   = ctl.illegal;
  assign alu_op    = ctl.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected list of
// per-cycle strobe sets, which is consumed cycle by cycle against the outputs.
module tb_control_sequencer;

  localparam logic [31:0] M_PCOUT = 32'd1 << 0,  M_ZHIGH = 32'd1 << 1,  M_ZLOW  = 32'd1 << 2;
  localparam logic [31:0] M_MDROUT = 32'd1 << 3, M_HIOUT = 32'd1 << 4,  M_LOOUT = 32'd1 << 5;
  localparam logic [31:0] M_INPORT = 32'd1 << 6, M_COUT  = 32'd1 << 7,  M_PCIN  = 32'd1 << 8;
  localparam logic [31:0] M_IRIN  = 32'd1 << 9,  M_MARIN = 32'd1 << 10, M_MDRIN = 32'd1 << 11;
  localparam logic [31:0] M_YIN   = 32'd1 << 12, M_ZIN   = 32'd1 << 13, M_HIIN  = 32'd1 << 14;
  localparam logic [31:0] M_LOIN  = 32'd1 << 15, M_OUTP  = 32'd1 << 16, M_GRA   = 32'd1 << 17;
  localparam logic [31:0] M_GRB   = 32'd1 << 18, M_GRC   = 32'd1 << 19, M_RIN   = 32'd1 << 20;
  localparam logic [31:0] M_ROUT  = 32'd1 << 21, M_BAOUT = 32'd1 << 22, M_INCPC = 32'd1 << 23;
  localparam logic [31:0] M_READ  = 32'd1 << 24, M_WRITE = 32'd1 << 25, M_ILL   = 32'd1 << 26;
  localparam logic [31:0] BUS = M_PCOUT | M_ZHIGH | M_ZLOW | M_MDROUT | M_HIOUT | M_LOOUT |
                                M_INPORT | M_COUT | M_ROUT | M_BAOUT;
  localparam logic [31:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [31:0] V_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
  localparam logic [31:0] V_WB = M_ZLOW | M_GRA | M_RIN;

  logic clock, reset, mem_ready;
  logic [31:0] ir;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin;
  logic Gra, Grb, Grc, Rin, Rout, BAout, IncPC, Read, Write, run, illegal;
  logic [4:0] alu_op;
  logic [3:0] dbg_state;

  control_sequencer dut (
    .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .IncPC(IncPC), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .illegal(illegal), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          w_q[$];
  logic [31:0] hist[$];
  bit          halted = 1'b0;
  int          pos = 0;
  logic [4:0]  cur_op = 5'd0;
  logic [31:0] ir_next = 32'd0;

  function automatic logic [31:0] A(input logic [4:0] f);
    return {f, 27'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void push(input logic [31:0] v, input bit w);
    exp_q.push_back(v);
    w_q.push_back(w);
  endfunction

  // Expand one instruction word into its expected cycle sequence.
  task automatic start_instr(input logic [31:0] word);
    logic [4:0] op;
    op = word[31:27];
    ir_next = word;
    cur_op = op;
    pos = 0;
    hist.delete();
    push(V_T0, 0); push(V_T1, 1); push(M_MDROUT | M_IRIN, 0);
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, 0); push(M_GRC | M_ROUT | M_ZIN | A(op), 0); push(V_WB, 0);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      push(M_GRB | M_ROUT | M_YIN, 0);
      push(M_COUT | M_ZIN | A(op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd5 : 5'd6), 0);
      push(V_WB, 0);
    end else if (op == 5'd15 || op == 5'd16) begin
      push(M_GRA | M_ROUT | M_YIN, 0); push(M_GRB | M_ROUT | M_ZIN | A(op), 0);
      push(M_ZLOW | M_LOIN, 0); push(M_ZHIGH | M_HIIN, 0);
    end else if (op == 5'd17 || op == 5'd18) begin
      push(M_GRB | M_ROUT | M_ZIN | A(op), 0); push(V_WB, 0);
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, 0); push(M_COUT | M_ZIN | A(5'd3), 0);
      if (op == 5'd1) push(V_WB, 0);
      else if (op == 5'd0) begin
        push(M_ZLOW | M_MARIN, 0); push(M_READ | M_MDRIN, 1); push(M_MDROUT | M_GRA | M_RIN, 0);
      end else begin
        push(M_ZLOW | M_MARIN, 0); push(M_GRA | M_ROUT | M_MDRIN, 0); push(M_WRITE, 1);
      end
    end else begin
      case (op)
        5'd20: push(M_GRA | M_ROUT | M_PCIN, 0);
        5'd22: push(M_INPORT | M_GRA | M_RIN, 0);
        5'd23: push(M_GRA | M_ROUT | M_OUTP, 0);
        5'd24: push(M_HIOUT | M_GRA | M_RIN, 0);
        5'd25: push(M_LOOUT | M_GRA | M_RIN, 0);
        5'd26, 5'd27: push(32'd0, 0);
        default: push(M_ILL, 0);
      endcase
    end
  endtask

  task automatic step_cycle(input logic rst, input logic mr);
    logic [31:0] act, exp_v;
    logic        exp_run;
    @(posedge clock);
    #1;
    reset = rst;
    mem_ready = mr;
    ir = ir_next;
    @(negedge clock);
    act = {alu_op, illegal, Write, Read, IncPC, BAout, Rout, Rin, Grc, Grb, Gra, OutPortin,
           LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin, Cout, InPortout, LOout, HIout,
           MDRout, Zlowout, Zhighout, PCout};
    hist.push_back(act);
    if (rst || halted || exp_q.size() == 0) begin
      exp_v = 32'd0;
      exp_run = 1'b0;
    end else begin
      exp_v = exp_q[0];
      exp_run = 1'b1;
    end
    check("outputs", act, exp_v);
    check("run", {31'd0, run}, {31'd0, exp_run});
    check("bus_sources", {31'd0, ($countones(act & BUS) <= 1)}, 32'd1);
    if (rst) begin
      exp_q.delete();
      w_q.delete();
      halted = 1'b0;
    end else if (!halted && exp_q.size() > 0 && !(w_q[0] && !mr)) begin
      void'(exp_q.pop_front());
      void'(w_q.pop_front());
      pos++;
      if (exp_q.size() == 0 && cur_op == 5'd27) halted = 1'b1;
    end
  endtask

  // fw/ew: wait cycles held on the fetch and execute memory steps (directed mode).
  task automatic run_instr(input logic [31:0] word, input int fw, input int ew,
                           input bit rnd, output int ncyc);
    int waited;
    bit mr;
    waited = 0;
    ncyc = 0;
    start_instr(word);
    while (exp_q.size() > 0 && !halted && ncyc < 200) begin
      if (w_q[0]) begin
        if (rnd) mr = ($urandom_range(0, 1) == 1);
        else     mr = (waited >= ((pos == 1) ? fw : ew));
        waited = mr ? 0 : waited + 1;
      end else begin
        mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      step_cycle(1'b0, mr);
      ncyc++;
    end
    check("instr_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n;
    logic [4:0] rop;
    reset = 1'b1;
    mem_ready = 1'b0;
    ir = 32'd0;

    step_cycle(1'b1, 1'b1);
    step_cycle(1'b1, 1'b1);
    check("reset_outputs", hist[1], 32'd0);

    run_instr(32'h18918000, 0, 0, 0, n);
    check("add_latency", n, 32'd6);
    check("add_T3", hist[3], M_GRB | M_ROUT | M_YIN);
    check("add_T4", hist[4], M_GRC | M_ROUT | M_ZIN | 32'h1800_0000);
    check("add_T5", hist[5], V_WB);

    run_instr(32'h0080_0065, 0, 2, 0, n);
    check("ld_first_T0", hist[0], V_T0);
    check("ld_latency", n, 32'd10);
    for (int i = 6; i < 9; i++) check("ld_read_hold", hist[i], M_READ | M_MDRIN);
    check("ld_wb", hist[9], M_MDROUT | M_GRA | M_RIN);

    run_instr({5'b10000, 4'd3, 4'd4, 19'd0}, 0, 0, 0, n);
    check("mul_latency", n, 32'd7);
    check("mul_T5", hist[5], M_ZLOW | M_LOIN);
    check("mul_T6", hist[6], M_ZHIGH | M_HIIN);

    run_instr({5'b10011, 27'd0}, 0, 0, 0, n);
    check("br_latency", n, 32'd4);
    check("br_illegal", hist[3], M_ILL);

    run_instr({5'b00010, 27'h0123}, 1, 1, 0, n);
    check("st_latency_waits", n, 32'd10);
    check("st_write", hist[9], M_WRITE);

    run_instr({5'b10001, 27'h0}, 0, 0, 0, n);
    check("neg_latency", n, 32'd5);

    for (int k = 0; k < 80; k++) begin
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd27) rop = 5'd26;
      run_instr({rop, 27'($urandom())}, 0, 0, 1, n);
    end

    run_instr({5'b11011, 27'd0}, 0, 0, 0, n);
    check("halt_latency", n, 32'd4);
    for (int k = 0; k < 20; k++) step_cycle(1'b0, 1'($urandom_range(0, 1)));
    check("halt_quiet", hist[hist.size() - 1], 32'd0);
    step_cycle(1'b1, 1'b1);
    run_instr({5'b11010, 27'd0}, 0, 0, 0, n);
    check("after_halt_T0", hist[0], V_T0);
    check("nop_latency", n, 32'd4);

    start_instr(32'h18918000);
    step_cycle(1'b0, 1'b1);
    step_cycle(1'b0, 1'b0);
    check("pre_reset_read", hist[1], V_T1);
    step_cycle(1'b1, 1'b0);
    check("reset_drops_read", hist[2], 32'd0);
    run_instr({5'b11001, 27'd0}, 0, 0, 0, n);
    check("post_reset_T0", hist[0], V_T0);
    check("mflo_latency", n, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Mini-SRC single-bus datapath. Steps each instruction through fetch (T0–T2) and execute (T3–T7) and drives the bus source-select strobes, register load strobes, ALU opcode and memory handshake. Sits beside the IR; its Gra/Grb/Grc/Rin/Rout/BAout feed the select-and-encode block, which produces the per-register R*out/R*in lines.

## Interface
- No parameters.
- clock  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- ir  in  32  instruction register; opcode = ir[31:27]
- mem_ready  in  1  memory completion; sampled at clock edge in memory states
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout  out  1 each  bus source strobes (at most one, or Rout, high per cycle)
- PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, OutPortin  out  1 each  register load strobes
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-field select and GPR in/out
- IncPC  out  1  ALU computes PC+1 this cycle
- Read, Write  out  1 each  memory request; MDR takes memory data when Read=1
- alu_op  out  5  ALU function code
- run  out  1  high while executing, low in HALT
- illegal  out  1  one-cycle pulse on unsupported opcode

## Operation
- Outputs are a combinational function of registered state and ir only (Moore). Any strobe not listed for a state is 0; alu_op defaults to 0.
- Fetch: T0 PCout, MARin, IncPC, Zin. T1 Zlowout, PCin, Read, MDRin (memory wait). T2 MDRout, IRin. T3 decodes ir loaded at end of T2.
- Execute by opcode (steps after T3 listed in order; after last step go to T0):
  - add..shl (00011–01011): Grb,Rout,Yin | Grc,Rout,Zin, alu_op=opcode | Zlowout,Gra,Rin.
  - addi/andi/ori (01100–01110): Grb,Rout,Yin | Cout,Zin, alu_op=00011/00101/00110 | Zlowout,Gra,Rin.
  - div 01111, mul 10000: Gra,Rout,Yin | Grb,Rout,Zin, alu_op=opcode | Zlowout,LOin | Zhighout,HIin.
  - neg 10001, not 10010: Grb,Rout,Zin, alu_op=opcode | Zlowout,Gra,Rin.
  - ldi 00001: Grb,BAout,Yin | Cout,Zin, alu_op=00011 | Zlowout,Gra,Rin.
  - ld 00000: ldi's first two steps | Zlowout,MARin | Read,MDRin (memory wait) | MDRout,Gra,Rin.
  - st 00010: ldi's first two steps | Zlowout,MARin | Gra,Rout,MDRin | Write (memory wait).
  - jr 10100: Gra,Rout,PCin. in 10110: InPortout,Gra,Rin. out 10111: Gra,Rout,OutPortin.
  - mfhi 11000: HIout,Gra,Rin. mflo 11001: LOout,Gra,Rin.
  - nop 11010: T3 has no strobes, then T0.
  - halt 11011: enter HALT; run=0, all strobes 0; leave only via reset.
  - all other opcodes (br, jal, 11100–11111): T3 asserts illegal only, then T0.
- Memory wait states (T1, ld Read step, st Write step): strobes held every cycle; advance only on edge with mem_ready=1; stay otherwise, indefinitely.

## Timing
- While reset=1: state forced to T0 on the edge; all outputs forced 0, run=0. First cycle after reset deasserts: T0 with run=1.
- Reset takes priority over mem_ready and HALT; reset mid-wait abandons the access (Read/Write drop the cycle reset is sampled high).
- Latency with mem_ready tied high: fetch 3 cycles; ALU reg/imm 6; ld 8; st 8; mul/div 7; neg/not 5; jr/in/out/mfhi/mflo/nop/illegal 4.
- Each added wait cycle on a memory state adds exactly one cycle.
- illegal is high exactly one cycle per unsupported instruction.
- No two bus-source strobes (including Rout, BAout) high in the same cycle in any state.

## Test plan
- Reset 2 cycles, mem_ready=1, ir=add R1,R2,R3 (0x18918000) -> T0..T5 over 6 cycles; T4 alu_op=00011 with Grc,Rout,Zin; T5 Zlowout,Gra,Rin; cycle 7 back at T0.
- ld R1,0x65(R0) with mem_ready low 2 extra cycles in ld Read step -> Read,MDRin held 3 cycles; MDRout,Gra,Rin the cycle after mem_ready; 10 cycles total.
- mul R3,R4 (opcode 10000) -> T5 Zlowout,LOin; T6 Zhighout,HIin; 7 cycles.
- ir opcode 10011 (br) -> illegal high one cycle at T3, no other strobes, next cycle T0.
- halt (opcode 11011) -> run=0 and all strobes 0 for 20 cycles; reset -> T0, run=1.
- Reset asserted in T1 with mem_ready=0 -> Read low next cycle; state T0 after reset release.
